// File: rtl/seg7_mux_ctrl_if.sv
// AXI4-Lite register bus bundle for the multiplexed 7-segment controller.
interface seg7_mux_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/seg7_mux_ctrl.sv
// AXI4-Lite controlled multiplexed 7-segment driver (2..16 digits) with
// per-digit blanking, 16-level PWM brightness and programmable refresh.
// Optional per-digit blink is built when SEG7_BLINK_EN is defined.
module seg7_mux_ctrl #(
  parameter int unsigned NDISP       = 8,
  parameter bit          MODE_DISP   = 1'b1,
  parameter bit          MODE_SEG    = 1'b1,
  parameter int unsigned REFRESH_CNT = 100_000,
  parameter int unsigned ADDR_WIDTH  = 5,
  parameter int unsigned DATA_WIDTH  = 32
) (
  input  logic               clk,
  input  logic               nrst,
  seg7_mux_ctrl_if.slave     bus,
  output logic [NDISP-1:0]   seg,
  output logic [6:0]         ABCDEFG,
  output logic               DP
);

`ifdef SEG7_BLINK_EN
  localparam int unsigned NUM_WORDS = 8;
`else
  localparam int unsigned NUM_WORDS = 6;
`endif

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Storage masks: bits belonging to digits >= NDISP are never kept.
  function automatic logic [31:0] nib_mask(input int unsigned base);
    logic [31:0] m;
    m = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (base + i < NDISP) m[4*i +: 4] = 4'hF;
    end
    return m;
  endfunction

  localparam logic [31:0] LO_MASK  = nib_mask(0);
  localparam logic [31:0] HI_MASK  = nib_mask(8);
  localparam logic [15:0] DIG_MASK = 16'((33'd1 << NDISP) - 33'd1);

  // Reset-time outputs: digit 0 showing "0" at full brightness.
  localparam logic [NDISP-1:0] SEG_ONE   = NDISP'(1);
  localparam logic [NDISP-1:0] SEG_RST   = MODE_DISP ? ~SEG_ONE : SEG_ONE;
  localparam logic [6:0]       ABCD_RST  = MODE_SEG ? 7'h7E : 7'h01;
  localparam logic             DP_RST    = ~MODE_SEG;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA} rstate_t;

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] d,
                                        input logic [3:0]  s);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? d[8*b +: 8] : old[8*b +: 8];
    return r;
  endfunction

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] p;
    case (n)
      4'h0: p = 7'b1111110;
      4'h1: p = 7'b0110000;
      4'h2: p = 7'b1101101;
      4'h3: p = 7'b1111001;
      4'h4: p = 7'b0110011;
      4'h5: p = 7'b1011011;
      4'h6: p = 7'b1011111;
      4'h7: p = 7'b1110000;
      4'h8: p = 7'b1111111;
      4'h9: p = 7'b1111011;
      4'hA: p = 7'b1110111;
      4'hB: p = 7'b0011111;
      4'hC: p = 7'b1001110;
      4'hD: p = 7'b0111101;
      4'hE: p = 7'b1001111;
      default: p = 7'b1000111;
    endcase
    return p;
  endfunction

  // Register state
  logic [31:0] dig_lo_q, dig_hi_q;
  logic [15:0] dp_q, blank_q;
  logic [3:0]  bright_q;
  logic        en_q;
  logic [19:0] refresh_q;
`ifdef SEG7_BLINK_EN
  logic [15:0] blink_q;
  logic [7:0]  blink_div_q;
  logic [7:0]  blink_cnt_q;
  logic        blink_ph_q;
`endif

  // Scan state
  logic [19:0] rcnt_q;
  logic [3:0]  idx_q;
  logic [3:0]  phase_q;

  // Bus FSM state and captures
  wstate_t                 wstate;
  rstate_t                 rstate;
  logic [ADDR_WIDTH-1:0]   aw_addr_q;
  logic [DATA_WIDTH-1:0]   w_data_q;
  logic [3:0]              w_strb_q;

  logic                    aw_fire_c, w_fire_c, ar_fire_c;
  logic                    wr_commit_c;
  logic [ADDR_WIDTH-1:0]   wr_addr_c;
  logic [31:0]             wr_data_c;
  logic [3:0]              wr_strb_c;
  logic [31:0]             wr_a32_c, rd_a32_c;
  logic                    wr_ok_c, rd_ok_c;
  logic [2:0]              wr_sel_c, rd_sel_c;
  logic [31:0]             regs_c [8];
  logic [31:0]             wr_merged_c;
  logic [31:0]             rd_data_c;
  logic                    refresh_wr_c;
  logic                    slot_end_c;
  logic                    active_c;
  logic [3:0]              nib_c;
  logic [63:0]             digits_c;
  logic [NDISP-1:0]        seg_on_c;
  logic [6:0]              pat_c;
  logic                    dp_bit_c;
  logic                    unused_c;

  assign aw_fire_c = bus.awvalid & bus.awready;
  assign w_fire_c  = bus.wvalid & bus.wready;
  assign ar_fire_c = bus.arvalid & bus.arready;

  // Register file view used by both the read mux and the byte-merge on write
  always_comb begin
    for (int i = 0; i < 8; i++) regs_c[i] = '0;
    regs_c[0] = dig_lo_q;
    regs_c[1] = dig_hi_q;
    regs_c[2] = {16'b0, dp_q};
    regs_c[3] = {16'b0, blank_q};
    regs_c[4] = {23'b0, en_q, 4'b0, bright_q};
    regs_c[5] = {12'b0, refresh_q};
`ifdef SEG7_BLINK_EN
    regs_c[6] = {16'b0, blink_q};
    regs_c[7] = {24'b0, blink_div_q};
`endif
  end

  // Effective write address/data: captured copy if that channel came first
  always_comb begin
    wr_addr_c   = bus.awaddr;
    wr_data_c   = 32'(bus.wdata);
    wr_strb_c   = 4'(bus.wstrb);
    wr_commit_c = 1'b0;
    if (wstate == W_HAVE_AW) wr_addr_c = aw_addr_q;
    if (wstate == W_HAVE_W) begin
      wr_data_c = 32'(w_data_q);
      wr_strb_c = w_strb_q;
    end
    case (wstate)
      W_IDLE:    wr_commit_c = aw_fire_c & w_fire_c;
      W_HAVE_AW: wr_commit_c = w_fire_c;
      W_HAVE_W:  wr_commit_c = aw_fire_c;
      default:   wr_commit_c = 1'b0;
    endcase
  end

  // Address decode; anything beyond the implemented words is SLVERR
  always_comb begin
    wr_a32_c    = 32'(wr_addr_c);
    rd_a32_c    = 32'(bus.araddr);
    wr_ok_c     = wr_a32_c[31:2] < 30'(NUM_WORDS);
    rd_ok_c     = rd_a32_c[31:2] < 30'(NUM_WORDS);
    wr_sel_c    = wr_a32_c[4:2];
    rd_sel_c    = rd_a32_c[4:2];
    wr_merged_c = merge(regs_c[wr_sel_c], wr_data_c, wr_strb_c);
    rd_data_c   = rd_ok_c ? regs_c[rd_sel_c] : 32'h0;
  end

  assign refresh_wr_c = wr_commit_c & wr_ok_c & (wr_sel_c == 3'd5);
  assign unused_c     = ^{bus.awprot, bus.arprot, wr_a32_c[1:0], rd_a32_c[1:0]};

  // Write channel FSM: AW and W captured independently, commit on the later one
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wstate      <= W_IDLE;
      bus.awready <= 1'b0;
      bus.wready  <= 1'b0;
      bus.bvalid  <= 1'b0;
      bus.bresp   <= RESP_OKAY;
      aw_addr_q   <= '0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
    end else begin
      case (wstate)
        W_IDLE: begin
          if (aw_fire_c && w_fire_c) begin
            wstate      <= W_RESP;
            bus.awready <= 1'b0;
            bus.wready  <= 1'b0;
            bus.bvalid  <= 1'b1;
            bus.bresp   <= wr_ok_c ? RESP_OKAY : RESP_SLVERR;
          end else if (aw_fire_c) begin
            wstate      <= W_HAVE_AW;
            aw_addr_q   <= bus.awaddr;
            bus.awready <= 1'b0;
            bus.wready  <= 1'b1;
          end else if (w_fire_c) begin
            wstate      <= W_HAVE_W;
            w_data_q    <= bus.wdata;
            w_strb_q    <= 4'(bus.wstrb);
            bus.awready <= 1'b1;
            bus.wready  <= 1'b0;
          end else begin
            bus.awready <= 1'b1;
            bus.wready  <= 1'b1;
          end
        end
        W_HAVE_AW: begin
          if (w_fire_c) begin
            wstate     <= W_RESP;
            bus.wready <= 1'b0;
            bus.bvalid <= 1'b1;
            bus.bresp  <= wr_ok_c ? RESP_OKAY : RESP_SLVERR;
          end
        end
        W_HAVE_W: begin
          if (aw_fire_c) begin
            wstate      <= W_RESP;
            bus.awready <= 1'b0;
            bus.bvalid  <= 1'b1;
            bus.bresp   <= wr_ok_c ? RESP_OKAY : RESP_SLVERR;
          end
        end
        default: begin
          if (bus.bready) begin
            wstate      <= W_IDLE;
            bus.bvalid  <= 1'b0;
            bus.awready <= 1'b1;
            bus.wready  <= 1'b1;
          end
        end
      endcase
    end
  end

  // Read channel FSM: data/resp registered at the AR handshake, held until rready
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rstate      <= R_IDLE;
      bus.arready <= 1'b0;
      bus.rvalid  <= 1'b0;
      bus.rdata   <= '0;
      bus.rresp   <= RESP_OKAY;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (ar_fire_c) begin
            rstate      <= R_DATA;
            bus.arready <= 1'b0;
            bus.rvalid  <= 1'b1;
            bus.rdata   <= DATA_WIDTH'(rd_data_c);
            bus.rresp   <= rd_ok_c ? RESP_OKAY : RESP_SLVERR;
          end else begin
            bus.arready <= 1'b1;
          end
        end
        default: begin
          if (bus.rready) begin
            rstate      <= R_IDLE;
            bus.rvalid  <= 1'b0;
            bus.arready <= 1'b1;
          end
        end
      endcase
    end
  end

  // Register updates on write commit
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      dig_lo_q    <= '0;
      dig_hi_q    <= '0;
      dp_q        <= '0;
      blank_q     <= '0;
      bright_q    <= 4'hF;
      en_q        <= 1'b1;
      refresh_q   <= 20'(REFRESH_CNT);
`ifdef SEG7_BLINK_EN
      blink_q     <= '0;
      blink_div_q <= 8'd64;
`endif
    end else if (wr_commit_c && wr_ok_c) begin
      case (wr_sel_c)
        3'd0: dig_lo_q <= wr_merged_c & LO_MASK;
        3'd1: dig_hi_q <= wr_merged_c & HI_MASK;
        3'd2: dp_q     <= wr_merged_c[15:0] & DIG_MASK;
        3'd3: blank_q  <= wr_merged_c[15:0] & DIG_MASK;
        3'd4: begin
          bright_q <= wr_merged_c[3:0];
          en_q     <= wr_merged_c[8];
        end
        3'd5: refresh_q <= (wr_merged_c[19:0] == 20'd0) ? 20'd1 : wr_merged_c[19:0];
`ifdef SEG7_BLINK_EN
        3'd6: blink_q     <= wr_merged_c[15:0] & DIG_MASK;
        3'd7: blink_div_q <= (wr_merged_c[7:0] == 8'd0) ? 8'd1 : wr_merged_c[7:0];
`endif
        default: ;
      endcase
    end
  end

  assign slot_end_c = (rcnt_q >= refresh_q - 20'd1);

  // Slot timer, digit index and free-running PWM phase
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rcnt_q  <= '0;
      idx_q   <= '0;
      phase_q <= '0;
    end else begin
      phase_q <= phase_q + 4'd1;
      if (refresh_wr_c) begin
        rcnt_q <= '0;
      end else if (slot_end_c) begin
        rcnt_q <= '0;
        idx_q  <= (idx_q == 4'(NDISP - 1)) ? 4'd0 : idx_q + 4'd1;
      end else begin
        rcnt_q <= rcnt_q + 20'd1;
      end
    end
  end

`ifdef SEG7_BLINK_EN
  // Blink phase flips after every BLINK_DIV complete scan frames
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
    end else if (!refresh_wr_c && slot_end_c && (idx_q == 4'(NDISP - 1))) begin
      if (blink_cnt_q >= blink_div_q - 8'd1) begin
        blink_cnt_q <= '0;
        blink_ph_q  <= ~blink_ph_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 8'd1;
      end
    end
  end
`endif

  // Pixel gating and polarity for the active digit
  always_comb begin
    digits_c = {dig_hi_q, dig_lo_q};
    nib_c    = digits_c[{idx_q, 2'b00} +: 4];
    active_c = en_q & ~blank_q[idx_q] & (phase_q <= bright_q);
`ifdef SEG7_BLINK_EN
    if (blink_ph_q && blink_q[idx_q]) active_c = 1'b0;
`endif
    seg_on_c = active_c ? (SEG_ONE << idx_q) : '0;
    pat_c    = active_c ? hex7(nib_c) : 7'b0;
    dp_bit_c = active_c & dp_q[idx_q];
  end

  // Registered pin drivers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      seg     <= SEG_RST;
      ABCDEFG <= ABCD_RST;
      DP      <= DP_RST;
    end else begin
      seg     <= MODE_DISP ? ~seg_on_c : seg_on_c;
      ABCDEFG <= MODE_SEG ? pat_c : ~pat_c;
      DP      <= MODE_SEG ? dp_bit_c : ~dp_bit_c;
    end
  end

endmodule

// File: tb/tb_seg7_mux_ctrl.sv
// Directed bench for seg7_mux_ctrl (NDISP=8, active-low selects, active-high segments).
module tb_seg7_mux_ctrl;
  logic       clk;
  logic       nrst;
  logic [7:0] seg;
  logic [6:0] abcdefg;
  logic       dp;

  int total = 0;
  int bad   = 0;

  seg7_mux_ctrl_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) bus ();

  seg7_mux_ctrl #(
    .NDISP(8), .MODE_DISP(1'b1), .MODE_SEG(1'b1), .REFRESH_CNT(100_000),
    .ADDR_WIDTH(6), .DATA_WIDTH(32)
  ) dut (
    .clk(clk), .nrst(nrst), .bus(bus), .seg(seg), .ABCDEFG(abcdefg), .DP(dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly,
                           output logic [1:0] resp, output logic b_now);
    int c;
    bit aw_done, w_done, aw_hit, w_hit;
    aw_done = 0; w_done = 0; c = 0;
    bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
    while (!(aw_done && w_done) && c < 50) begin
      bus.awvalid = !aw_done && (c >= aw_dly);
      bus.wvalid  = !w_done && (c >= w_dly);
      aw_hit = bus.awvalid && bus.awready;
      w_hit  = bus.wvalid && bus.wready;
      step();
      if (aw_hit) aw_done = 1;
      if (w_hit)  w_done = 1;
      c++;
    end
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    b_now = bus.bvalid;
    c = 0;
    while (!bus.bvalid && c < 20) begin
      step();
      c++;
    end
    if (!bus.bvalid) chk("bvalid_timeout", 32'(bus.bvalid), 32'd1);
    resp = bus.bresp;
    bus.bready = 1'b1;
    step();
    bus.bready = 1'b0;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input string tag);
    logic [1:0] r;
    logic b;
    axi_write(a, d, 4'hF, 0, 0, r, b);
    chk(tag, 32'(r), 32'd0);
  endtask

  task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] resp);
    int c;
    bit hit;
    c = 0; hit = 0;
    bus.araddr  = a;
    bus.arvalid = 1'b1;
    while (!hit && c < 50) begin
      hit = bus.arready;
      step();
      c++;
    end
    bus.arvalid = 1'b0;
    c = 0;
    while (!bus.rvalid && c < 20) begin
      step();
      c++;
    end
    if (!bus.rvalid) chk("rvalid_timeout", 32'(bus.rvalid), 32'd1);
    d = bus.rdata;
    resp = bus.rresp;
    bus.rready = 1'b1;
    step();
    bus.rready = 1'b0;
  endtask

  task automatic rd_chk(input logic [5:0] a, input logic [31:0] exp, input logic [1:0] exp_resp,
                        input string tag);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(a, d, r);
    chk({tag, "_data"}, d, exp);
    chk({tag, "_resp"}, 32'(r), 32'(exp_resp));
  endtask

  task automatic wait_seg(input logic [7:0] v, input string tag);
    int c;
    c = 0;
    while (seg !== v && c < 300) begin
      step();
      c++;
    end
    chk(tag, 32'(seg), 32'(v));
  endtask

  task automatic run_len(input logic [7:0] v, output int n);
    n = 0;
    while (seg === v && n < 60) begin
      n++;
      step();
    end
  endtask

  task automatic observe(input int n, input logic [7:0] v, output int n_on, output int n_abc,
                         output int n_eq);
    n_on = 0; n_abc = 0; n_eq = 0;
    for (int i = 0; i < n; i++) begin
      if (seg !== 8'hFF) n_on++;
      if (abcdefg !== 7'h00) n_abc++;
      if (seg === v) n_eq++;
      step();
    end
  endtask

  logic [1:0]  resp_w, resp_r;
  logic [31:0] rdat;
  logic        b_now;
  int          n, n_on, n_abc, n_eq;

  initial begin
    nrst = 1'b0;
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", 32'(bus.awready), 32'd0);
    chk("rst_arready", 32'(bus.arready), 32'd0);
    chk("rst_bvalid",  32'(bus.bvalid),  32'd0);
    chk("rst_rvalid",  32'(bus.rvalid),  32'd0);
    chk("rst_rdata",   bus.rdata,        32'd0);
    chk("rst_seg",     32'(seg),         32'hFE);
    chk("rst_abcdefg", 32'(abcdefg),     32'h7E);
    chk("rst_dp",      32'(dp),          32'd0);
    nrst = 1'b1;
    step();
    chk("post_rst_awready", 32'(bus.awready), 32'd1);
    chk("post_rst_wready",  32'(bus.wready),  32'd1);
    chk("post_rst_arready", 32'(bus.arready), 32'd1);

    rd_chk(6'h00, 32'h0,       2'b00, "rd_dig_lo");
    rd_chk(6'h04, 32'h0,       2'b00, "rd_dig_hi");
    rd_chk(6'h08, 32'h0,       2'b00, "rd_dp");
    rd_chk(6'h0C, 32'h0,       2'b00, "rd_blank");
    rd_chk(6'h10, 32'h10F,     2'b00, "rd_ctrl");
    rd_chk(6'h14, 32'h186A0,   2'b00, "rd_refresh");
`ifdef SEG7_BLINK_EN
    rd_chk(6'h18, 32'h0,       2'b00, "rd_blink");
    rd_chk(6'h1C, 32'd64,      2'b00, "rd_blink_div");
`else
    rd_chk(6'h18, 32'h0,       2'b10, "rd_0x18_unmapped");
    rd_chk(6'h1C, 32'h0,       2'b10, "rd_0x1c_unmapped");
`endif

    // Scan walk with distinct digits
    wr(6'h00, 32'h7654_3210, "wr_dig_lo");
    wr(6'h14, 32'd4, "wr_refresh4");
    rd_chk(6'h00, 32'h7654_3210, 2'b00, "rb_dig_lo");
    wait_seg(8'hFB, "scan_reach_d2");
    wait_seg(8'hF7, "scan_reach_d3");
    chk("d3_abcdefg", 32'(abcdefg), 32'h79);
    chk("d3_dp", 32'(dp), 32'd0);
    run_len(8'hF7, n);
    chk("d3_slot_len", 32'(n), 32'd4);
    chk("d4_seg", 32'(seg), 32'hEF);
    chk("d4_abcdefg", 32'(abcdefg), 32'h33);
    wait_seg(8'h7F, "scan_reach_d7");
    chk("d7_abcdefg", 32'(abcdefg), 32'h70);
    run_len(8'h7F, n);
    chk("wrap_to_d0", 32'(seg), 32'hFE);

    // Upper digits are not stored for NDISP=8; DP bits above 7 dropped
    wr(6'h04, 32'hFEDC_BA98, "wr_dig_hi");
    rd_chk(6'h04, 32'h0, 2'b00, "rb_dig_hi_masked");
    axi_write(6'h08, 32'h1234_00A5, 4'hF, 1, 0, resp_w, b_now);
    chk("w_first_bresp", 32'(resp_w), 32'd0);
    chk("w_first_bvalid_at_commit", 32'(b_now), 32'd1);
    rd_chk(6'h08, 32'h0000_00A5, 2'b00, "rb_dp_masked");
    axi_write(6'h00, 32'hAAAA_BBCC, 4'b0010, 0, 2, resp_w, b_now);
    chk("aw_first_bresp", 32'(resp_w), 32'd0);
    chk("aw_first_bvalid_at_commit", 32'(b_now), 32'd1);
    rd_chk(6'h00, 32'h7654_BB10, 2'b00, "rb_dig_lo_byte1");

    // Unmapped address
    axi_write(6'h20, 32'hFFFF_FFFF, 4'hF, 0, 0, resp_w, b_now);
    chk("unmapped_bresp", 32'(resp_w), 32'd2);
    rd_chk(6'h20, 32'h0, 2'b10, "unmapped_rd");
    rd_chk(6'h00, 32'h7654_BB10, 2'b00, "no_change_after_unmapped");
`ifndef SEG7_BLINK_EN
    axi_write(6'h18, 32'hFFFF_FFFF, 4'hF, 0, 0, resp_w, b_now);
    chk("wr_0x18_unmapped", 32'(resp_w), 32'd2);
`endif

    // REFRESH of zero becomes one
    wr(6'h14, 32'd0, "wr_refresh0");
    rd_chk(6'h14, 32'd1, 2'b00, "rb_refresh0_as1");

    // Brightness 3: four driven cycles out of sixteen
    wr(6'h14, 32'd1000, "wr_refresh1000");
    wr(6'h10, 32'h103, "wr_bright3");
    observe(16, 8'hFF, n_on, n_abc, n_eq);
    chk("bright3_sel_on", 32'(n_on), 32'd4);
    chk("bright3_seg_on", 32'(n_abc), 32'd4);

    // Disable: nothing driven
    wr(6'h10, 32'h00F, "wr_en0");
    observe(20, 8'hFF, n_on, n_abc, n_eq);
    chk("en0_sel_on", 32'(n_on), 32'd0);
    chk("en0_seg_on", 32'(n_abc), 32'd0);

    // Blank digit 0
    wr(6'h10, 32'h10F, "wr_ctrl_full");
    wr(6'h0C, 32'h01, "wr_blank0");
    wr(6'h14, 32'd4, "wr_refresh4b");
    wait_seg(8'h7F, "blank_reach_d7");
    run_len(8'h7F, n);
    chk("blank_d0_seg", 32'(seg), 32'hFF);
    chk("blank_d0_abcdefg", 32'(abcdefg), 32'h0);
    chk("blank_d0_dp", 32'(dp), 32'd0);
    run_len(8'hFF, n);
    chk("blank_d0_len", 32'(n), 32'd4);
    chk("after_blank_d1_seg", 32'(seg), 32'hFD);
    chk("after_blank_d1_abcdefg", 32'(abcdefg), 32'h30);
    wait_seg(8'hFB, "blank_reach_d2");
    chk("d2_abcdefg_b", 32'(abcdefg), 32'h1F);
    chk("d2_dp_on", 32'(dp), 32'd1);

    // Simultaneous read and write of DP: read sees the old value
    fork
      axi_write(6'h08, 32'h3C, 4'hF, 0, 0, resp_w, b_now);
      axi_read(6'h08, rdat, resp_r);
    join
    chk("rw_same_old", rdat, 32'hA5);
    rd_chk(6'h08, 32'h3C, 2'b00, "rw_same_new");

`ifdef SEG7_BLINK_EN
    wr(6'h0C, 32'h0, "wr_blank_clear");
    wr(6'h1C, 32'h0, "wr_blink_div0");
    rd_chk(6'h1C, 32'd1, 2'b00, "rb_blink_div0_as1");
    wr(6'h18, 32'h02, "wr_blink");
    wr(6'h14, 32'd2, "wr_refresh2");
    wait_seg(8'hFE, "blink_sync_d0");
    for (int w = 0; w < 3; w++) begin
      observe(32, 8'hFD, n_on, n_abc, n_eq);
      chk("blink_d1_visible_per_2frames", 32'(n_eq), 32'd2);
    end
    observe(64, 8'hFD, n_on, n_abc, n_eq);
    chk("blink_d1_visible_per_4frames", 32'(n_eq), 32'd4);
`endif

    // Reset in the middle of a write: AW accepted, W never sent
    bus.awaddr = 6'h00;
    bus.awvalid = 1'b1;
    step();
    bus.awvalid = 1'b0;
    nrst = 1'b0;
    #1;
    chk("midrst_awready", 32'(bus.awready), 32'd0);
    chk("midrst_bvalid", 32'(bus.bvalid), 32'd0);
    chk("midrst_seg", 32'(seg), 32'hFE);
    step();
    nrst = 1'b1;
    step();
    rd_chk(6'h00, 32'h0, 2'b00, "midrst_dig_lo");
    rd_chk(6'h10, 32'h10F, 2'b00, "midrst_ctrl");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
